// File: rtl/alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// alu_muldiv_iter
//   Multi-cycle RV32M-style multiply / divide / remainder unit. One operation
//   is in flight at a time. The multiplier is shift-add and the divider is
//   restoring; both step through a single shared BW+1-bit adder, one bit per
//   cycle.
//
//   Ports
//     clock      rising-edge system clock
//     reset_n    asynchronous, active-low reset
//     flush      synchronous kill of any in-flight, pending or held result
//     in_valid   op/d1/d2 are valid
//     in_ready   unit is idle and can accept an operation
//     op         funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//     d1, d2     rs1 / rs2 operands
//     out_valid  res is valid
//     out_ready  consumer takes res
//     res        result
//
//   Timing: an op accepted at edge k raises out_valid after edge k+BW+2.
//   CALC lasts BW+1 cycles (BW steps plus one closing cycle), then FIX
//   applies sign correction and special cases.
// ---------------------------------------------------------------------------
module alu_muldiv_iter #(
  parameter int BW    = 32,
  parameter int CNT_W = $clog2(BW) + 1
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    op,
  input  logic [BW-1:0] d1,
  input  logic [BW-1:0] d2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BW);
  localparam logic [BW-1:0]    MOST_NEG = {1'b1, {(BW-1){1'b0}}};

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       op_reg;
  logic             neg_reg;    // final result must be negated
  logic             ovf_reg;    // signed MOST_NEG / -1
  logic [BW-1:0]    d1_reg;     // raw dividend, returned on divide by zero
  logic [BW-1:0]    hi_reg;     // product high half / partial remainder
  logic [BW-1:0]    lo_reg;     // multiplier -> product low half / dividend -> quotient
  logic [BW-1:0]    opb_reg;    // multiplicand or divisor magnitude
  logic [BW-1:0]    res_reg;

  // ---- operand preparation at accept ------------------------------------
  logic          sign1, sign2;
  logic [BW-1:0] abs1, abs2;
  logic          accept;

  always_comb begin
    sign1 = d1[BW-1] & ((op == OP_MULH) | (op == OP_MULHSU) |
                        (op == OP_DIV)  | (op == OP_REM));
    sign2 = d2[BW-1] & ((op == OP_MULH) | (op == OP_DIV) | (op == OP_REM));
    abs1  = sign1 ? (~d1 + 1'b1) : d1;
    abs2  = sign2 ? (~d2 + 1'b1) : d2;
  end

  assign accept = (state_reg == S_IDLE) && in_valid && !flush;

  // ---- shared adder and one iteration step ------------------------------
  logic [BW:0]   add_a, add_b;
  logic          add_cin;
  logic [BW+1:0] sum_full;
  logic [BW:0]   shifted;
  logic          no_borrow;
  logic [BW-1:0] hi_step, lo_step;

  always_comb begin
    shifted = {hi_reg, lo_reg[BW-1]};
    if (op_reg[2]) begin
      // Divide: shifted + ~divisor + 1; carry out means shifted >= divisor.
      add_a   = shifted;
      add_b   = ~{1'b0, opb_reg};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, hi_reg};
      add_b   = {1'b0, (lo_reg[0] ? opb_reg : {BW{1'b0}})};
      add_cin = 1'b0;
    end
    sum_full  = {1'b0, add_a} + {1'b0, add_b} + {{(BW+1){1'b0}}, add_cin};
    no_borrow = sum_full[BW+1];
    if (op_reg[2]) begin
      hi_step = no_borrow ? sum_full[BW-1:0] : shifted[BW-1:0];
      lo_step = {lo_reg[BW-2:0], no_borrow};
    end else begin
      hi_step = sum_full[BW:1];
      lo_step = {sum_full[0], lo_reg[BW-1:1]};
    end
  end

  // ---- final correction ---------------------------------------------------
  logic [2*BW-1:0] neg_prod;
  logic [BW-1:0]   neg_lo, neg_hi, fix_val;
  logic            div_zero;

  always_comb begin
    neg_prod = ~{hi_reg, lo_reg} + 1'b1;
    neg_lo   = ~lo_reg + 1'b1;
    neg_hi   = ~hi_reg + 1'b1;
    div_zero = (opb_reg == {BW{1'b0}});
    fix_val  = {BW{1'b0}};
    case (op_reg)
      OP_MUL:                    fix_val = lo_reg;
      OP_MULH, OP_MULHSU, OP_MULHU:
        fix_val = neg_reg ? neg_prod[2*BW-1:BW] : hi_reg;
      OP_DIV:
        if (div_zero)     fix_val = {BW{1'b1}};
        else if (ovf_reg) fix_val = d1_reg;
        else              fix_val = neg_reg ? neg_lo : lo_reg;
      OP_DIVU:
        fix_val = div_zero ? {BW{1'b1}} : lo_reg;
      OP_REM:
        if (div_zero)     fix_val = d1_reg;
        else if (ovf_reg) fix_val = {BW{1'b0}};
        else              fix_val = neg_reg ? neg_hi : hi_reg;
      OP_REMU:
        fix_val = div_zero ? d1_reg : hi_reg;
      default:                   fix_val = {BW{1'b0}};
    endcase
  end

  // ---- state and datapath registers ---------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      op_reg    <= '0;
      neg_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      d1_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      opb_reg   <= '0;
      res_reg   <= '0;
    end else if (flush) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            state_reg <= S_CALC;
            cnt_reg   <= '0;
            op_reg    <= op;
            neg_reg   <= (op == OP_REM) ? sign1 : (sign1 ^ sign2);
            ovf_reg   <= ((op == OP_DIV) || (op == OP_REM)) &&
                         (d1 == MOST_NEG) && (d2 == {BW{1'b1}});
            d1_reg    <= d1;
            hi_reg    <= '0;
            lo_reg    <= op[2] ? abs1 : abs2;
            opb_reg   <= op[2] ? abs2 : abs1;
          end
        end
        S_CALC: begin
          if (cnt_reg == CNT_LAST) begin
            state_reg <= S_FIX;
          end else begin
            hi_reg  <= hi_step;
            lo_reg  <= lo_step;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_FIX: begin
          res_reg   <= fix_val;
          state_reg <= S_DONE;
        end
        default: begin
          if (out_ready) state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == S_IDLE);
  assign out_valid = (state_reg == S_DONE);
  assign res       = res_reg;

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_iter
//   Directed cases with hand-computed results, handshake/flush/reset checks,
//   then randomized operations checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_muldiv_iter;

  localparam int BW  = 32;
  localparam int LAT = BW + 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic [BW-1:0] d1 = '0;
  logic [BW-1:0] d2 = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] res;

  int tests_run = 0;
  int tests_failed = 0;

  alu_muldiv_iter #(.BW(BW)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .d1       (d1),
    .d2       (d2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .res      (res)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_res(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin pu = {32'd0, a} * {32'd0, b}; return pu[31:0]; end
      3'd1: begin ps = longint'(sa) * longint'(sb); pu = ps; return pu[63:32]; end
      3'd2: begin ps = longint'(sa) * longint'({32'd0, b}); pu = ps; return pu[63:32]; end
      3'd3: begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return sa / sb;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Wait for in_ready, issue, scramble inputs after acceptance, measure
  // latency, check result, hold out_ready low for 'hold' cycles, consume.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int hold);
    int n;
    logic [31:0] first;
    n = 0;
    while (!in_ready && n < 200) begin tick(); n++; end
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    op = o; d1 = a; d2 = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op = 3'($urandom); d1 = $urandom; d2 = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check({tag, "_lat"}, n, LAT);
    check({tag, "_res"}, res, exp);
    $display("[TB] %s op=%0d d1=0x%08h d2=0x%08h res=0x%08h exp=0x%08h lat=%0d",
             tag, o, a, b, res, exp, n);
    first = res;
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold"}, {res[31:2], out_valid, in_ready},
            {first[31:2], 1'b1, 1'b0});
      check({tag, "_hold_lo"}, {30'd0, res[1:0]}, {30'd0, first[1:0]});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_consumed"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$] = '{
    '{3'd0, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE},
    '{3'd3, 32'hFFFFFFFF, 32'h00000002, 32'h00000001},
    '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF},
    '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000},
    '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD},
    '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF},
    '{3'd5, 32'd100,      32'd7,        32'd14},
    '{3'd7, 32'd100,      32'd7,        32'd2},
    '{3'd5, 32'h00001234, 32'h00000000, 32'hFFFFFFFF},
    '{3'd6, 32'h00001234, 32'h00000000, 32'h00001234},
    '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000},
    '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000}
  };

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin : main
    int n;
    logic seen;
    logic [2:0]  ro;
    logic [31:0] ra, rb;

    #12;
    check("reset_state", {res[31:2], out_valid, in_ready}, 32'd1);
    check("reset_res_lo", {30'd0, res[1:0]}, 32'd0);
    reset_n = 1'b1;
    tick();

    // Directed; the first holds out_ready low for 5 cycles.
    foreach (vecs[i])
      run_op($sformatf("dir%0d", i), vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp,
             (i == 0) ? 5 : 0);

    // Flush at CALC cycle 10: no result, next op accepted at once.
    op = 3'd0; d1 = 32'd3; d2 = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc", {30'd0, out_valid, in_ready}, 32'd1);
    $display("[TB] flush_calc out_valid=%0d in_ready=%0d", out_valid, in_ready);
    run_op("after_flush", 3'd4, 32'hFFFFFF9C, 32'd7, ref_res(3'd4, 32'hFFFFFF9C, 32'd7), 0);

    // Flush with in_valid in IDLE: not accepted.
    op = 3'd5; d1 = 32'd50; d2 = 32'd5; in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (out_valid || !in_ready) seen = 1'b1;
      tick();
    end
    check("flush_idle", {31'd0, seen}, 32'd0);
    $display("[TB] flush_idle seen_busy=%0d", seen);

    // Flush while DONE, with out_ready also high: result dropped.
    op = 3'd0; d1 = 32'd6; d2 = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check("flush_done_lat", n, LAT);
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("flush_done", {30'd0, out_valid, in_ready}, 32'd1);
    $display("[TB] flush_done out_valid=%0d in_ready=%0d", out_valid, in_ready);

    // Reset mid-CALC: outputs return to reset values without a clock edge.
    op = 3'd1; d1 = 32'h12345678; d2 = 32'h9ABCDEF0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    #2 reset_n = 1'b0;
    #1;
    check("reset_mid", {res[31:2], out_valid, in_ready}, 32'd1);
    check("reset_mid_lo", {30'd0, res[1:0]}, 32'd0);
    $display("[TB] reset_mid res=0x%08h out_valid=%0d in_ready=%0d", res, out_valid, in_ready);
    #1 reset_n = 1'b1;
    tick();
    run_op("after_reset", 3'd0, 32'h12345678, 32'h9ABCDEF0,
           ref_res(3'd0, 32'h12345678, 32'h9ABCDEF0), 0);

    // Randomized against the reference model.
    for (int i = 0; i < 48; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op($sformatf("rnd%0d", i), ro, ra, rb, ref_res(ro, ra, rb),
             $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
